// File: rtl/mobo_bus_ctrl_pkg.sv
// Shared constants for the motherboard bus: command/status bit
// positions and the bus controller FSM state encoding.
package mobo_bus_ctrl_pkg;

    localparam int CTRL_START = 0;
    localparam int CTRL_WE    = 1;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERR   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/mobo_timeout_cnt.sv
// Request-cycle counter; expire flags the cycle that is the
// limit-th consecutive enabled cycle since the last clear.
module mobo_timeout_cnt #(
    parameter int limit = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (limit < 1) ? 1 : $clog2(limit + 1);

    logic [W-1:0] cnt;

    // count enabled cycles, restart on clear
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && (cnt == W'(limit - 1));

endmodule

// File: rtl/mobo_bus_ctrl.sv
// Motherboard bus controller: one req/ack memory transaction per START.
// Optional request timeout compiled in with MOBO_BUS_TIMEOUT_EN.
module mobo_bus_ctrl
    import mobo_bus_ctrl_pkg::*;
#(
    parameter int word_width     = 32,
    parameter int addr_width     = 16,
    parameter int timeout_cycles = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] mobo_ctrl,
    input  logic [addr_width-1:0] mobo_addr,
    input  logic [word_width-1:0] mobo_wdata,
    output logic [word_width-1:0] mobo_stat,
    output logic [word_width-1:0] mobo_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [word_width-1:0] mem_wdata,
    input  logic [word_width-1:0] mem_rdata,
    input  logic                  mem_ack
);

    state_t state;
    logic   busy;
    logic   done;
    logic   err;
    logic   start;
    logic   accept;
    logic   expire;
    logic   unused;

    assign start  = mobo_ctrl[CTRL_START];
    assign accept = (state == ST_IDLE) && start;
    assign unused = ^mobo_ctrl[word_width-1:2];

`ifdef MOBO_BUS_TIMEOUT_EN
    mobo_timeout_cnt #(
        .limit (timeout_cycles)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (state == ST_REQ),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // pack status flags into the status word
    always_comb begin
        mobo_stat            = '0;
        mobo_stat[STAT_BUSY] = busy;
        mobo_stat[STAT_DONE] = done;
        mobo_stat[STAT_ERR]  = err;
    end

    // transaction FSM with registered bus and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mobo_rdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        mem_we    <= mobo_ctrl[CTRL_WE];
                        mem_addr  <= mobo_addr;
                        mem_wdata <= mobo_wdata;
                        err       <= 1'b0;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            mobo_rdata <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else if (expire) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        state   <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mobo_bus_ctrl.sv
// Directed self-checking bench for mobo_bus_ctrl.
// Timeout cases run only when MOBO_BUS_TIMEOUT_EN is defined.
module tb_mobo_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mobo_ctrl;
    logic [15:0] mobo_addr;
    logic [31:0] mobo_wdata;
    logic [31:0] mobo_stat;
    logic [31:0] mobo_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;

    mobo_bus_ctrl #(
        .word_width     (32),
        .addr_width     (16),
        .timeout_cycles (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mobo_ctrl  (mobo_ctrl),
        .mobo_addr  (mobo_addr),
        .mobo_wdata (mobo_wdata),
        .mobo_stat  (mobo_stat),
        .mobo_rdata (mobo_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues START in the current cycle, then runs 20 observed cycles.
    // ack_at: cycle index (1 = first cycle after START edge) of ack, 0 = never.
    // smask: cycles in which a stray START with address 0x0999 is driven.
    task automatic txn(input logic we, input logic [15:0] a,
                       input logic [31:0] wd, input int ack_at,
                       input logic [31:0] rd, input logic [31:0] smask,
                       output int nreq, output int ndone, output int lat,
                       output logic [31:0] stat_d, output logic we_req);
        mobo_ctrl  = {30'd0, we, 1'b1};
        mobo_addr  = a;
        mobo_wdata = wd;
        step();
        mobo_ctrl = '0;
        nreq   = 0;
        ndone  = 0;
        lat    = 0;
        stat_d = '0;
        we_req = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_req) begin
                if (nreq == 0) we_req = mem_we;
                nreq++;
            end
            if (mobo_stat[1]) begin
                if (ndone == 0) begin
                    lat    = c;
                    stat_d = mobo_stat;
                end
                ndone++;
            end
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? rd : 32'h0;
            if (smask[c]) begin
                mobo_ctrl = 32'h1;
                mobo_addr = 16'h0999;
            end else begin
                mobo_ctrl = '0;
            end
            step();
        end
        mem_ack   = 1'b0;
        mobo_ctrl = '0;
    endtask

    int          nreq;
    int          ndone;
    int          lat;
    logic [31:0] stat_d;
    logic        we_req;
    int          cnt;

    initial begin
        rst        = 1'b1;
        mobo_ctrl  = '0;
        mobo_addr  = '0;
        mobo_wdata = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
        step();
        step();
        rst = 1'b0;

        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req || mobo_stat != 0) cnt++;
            step();
        end
        check("idle_active", cnt, 0);
        check("rst_stat", mobo_stat, 32'h0);
        check("rst_rdata", mobo_rdata, 32'h0);
        check("rst_we", {31'd0, mem_we}, 0);
        check("rst_addr", {16'd0, mem_addr}, 0);
        check("rst_wdata", mem_wdata, 32'h0);

        // read, ack in third request cycle
        txn(1'b0, 16'h0040, 32'h0, 3, 32'hDEADBEEF, 0,
            nreq, ndone, lat, stat_d, we_req);
        check("rd_nreq", nreq, 3);
        check("rd_ndone", ndone, 1);
        check("rd_lat", lat, 4);
        check("rd_stat_done", stat_d, 32'h2);
        check("rd_we", {31'd0, we_req}, 0);
        check("rd_rdata", mobo_rdata, 32'hDEADBEEF);
        check("rd_addr", {16'd0, mem_addr}, 32'h0040);

        // write, ack with first request
        txn(1'b1, 16'h1234, 32'hA5A5A5A5, 1, 32'h0BAD0BAD, 0,
            nreq, ndone, lat, stat_d, we_req);
        check("wr_nreq", nreq, 1);
        check("wr_ndone", ndone, 1);
        check("wr_lat", lat, 2);
        check("wr_we", {31'd0, we_req}, 1);
        check("wr_addr", {16'd0, mem_addr}, 32'h1234);
        check("wr_wdata", mem_wdata, 32'hA5A5A5A5);
        check("wr_rdata", mobo_rdata, 32'hDEADBEEF);

        // stray STARTs during REQ (cycle 2) and DONE (cycle 4)
        txn(1'b0, 16'h0040, 32'h0, 3, 32'h11112222, 32'h14,
            nreq, ndone, lat, stat_d, we_req);
        check("ign_nreq", nreq, 3);
        check("ign_ndone", ndone, 1);
        check("ign_addr", {16'd0, mem_addr}, 32'h0040);
        check("ign_rdata", mobo_rdata, 32'h11112222);

`ifdef MOBO_BUS_TIMEOUT_EN
        txn(1'b0, 16'h0077, 32'h0, 0, 32'h0, 0,
            nreq, ndone, lat, stat_d, we_req);
        check("to_nreq", nreq, 4);
        check("to_ndone", ndone, 1);
        check("to_lat", lat, 5);
        check("to_stat_done", stat_d, 32'h6);
        check("to_err_sticky", mobo_stat, 32'h4);
        check("to_rdata", mobo_rdata, 32'h11112222);

        txn(1'b0, 16'h0078, 32'h0, 4, 32'hCAFEF00D, 0,
            nreq, ndone, lat, stat_d, we_req);
        check("ack4_nreq", nreq, 4);
        check("ack4_lat", lat, 5);
        check("ack4_stat_done", stat_d, 32'h2);
        check("ack4_stat_after", mobo_stat, 32'h0);
        check("ack4_rdata", mobo_rdata, 32'hCAFEF00D);
`endif

        // reset in the middle of a request, late ack afterwards
        mobo_ctrl = 32'h1;
        mobo_addr = 16'h0055;
        step();
        mobo_ctrl = '0;
        step();
        check("mid_req", {31'd0, mem_req}, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_req", {31'd0, mem_req}, 0);
        check("mid_rst_stat", mobo_stat, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        step();
        mem_ack = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req || mobo_stat != 0) cnt++;
            step();
        end
        check("late_ack_active", cnt, 0);
        check("late_ack_rdata", mobo_rdata, 32'h0);

        txn(1'b0, 16'h0101, 32'h0, 1, 32'h13572468, 0,
            nreq, ndone, lat, stat_d, we_req);
        check("post_rst_lat", lat, 2);
        check("post_rst_rdata", mobo_rdata, 32'h13572468);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mobo_bus_ctrl.md
# mobo_bus_ctrl

Motherboard bus controller sitting directly downstream of the CPU read/write function states. It consumes the `mobo_ctrl` command word plus address and write data, runs one memory transaction per command over a req/ack handshake, and returns completion, error and read data through `mobo_stat` / `mobo_rdata`. It is the only block that drives the memory-side bus.

## Interface
- `word_width`, 32, width of command, status and data words
- `addr_width`, 16, memory address width
- `timeout_cycles`, 255, max REQ cycles before abort (used only with timeout compiled in)

- `clk`  input  1  clock
- `rst`  input  1  synchronous, active-high reset
- `mobo_ctrl`  input  word_width  bit0 START (one-cycle pulse), bit1 WE (1 = write); other bits ignored
- `mobo_addr`  input  addr_width  transaction address, sampled with START
- `mobo_wdata`  input  word_width  write data, sampled with START
- `mobo_stat`  output  word_width  bit0 BUSY, bit1 DONE (one-cycle pulse), bit2 ERR (sticky); other bits 0
- `mobo_rdata`  output  word_width  last completed read data
- `mem_req`  output  1  transaction request, held until ack
- `mem_we`  output  1  write strobe qualifier
- `mem_addr`  output  addr_width  registered address
- `mem_wdata`  output  word_width  registered write data
- `mem_rdata`  input  word_width  read data, valid with `mem_ack`
- `mem_ack`  input  1  one-cycle completion from memory

## Operation
- One clock `clk`; reset is synchronous, active-high on `rst`.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE: START=1 latches WE, address, wdata; clears ERR; -> REQ. START ignored in any other state.
- REQ: `mem_req`=1, `mem_we`=latched WE, BUSY=1. `mem_ack`=1 -> DONE; on read, `mem_rdata` captured into `mobo_rdata`.
- DONE: DONE=1, BUSY=0, `mem_req`=0 for exactly one cycle -> IDLE.
- ERR (timeout only): DONE=1, ERR set, `mem_req`=0 for one cycle -> IDLE. ERR stays set until next accepted START.
- `mem_ack` outside REQ ignored. `mobo_rdata` unchanged by writes, errors and reset-free idle cycles.
- `mem_addr`/`mem_wdata` hold latched values until next accepted START.

## Timing
- All outputs registered. Reset values: every output 0, state IDLE, `mobo_rdata` 0.
- START sampled at edge N -> `mem_req`=1 from cycle N+1.
- Ack during cycle M -> DONE (and `mobo_rdata` valid) in cycle M+1; minimum START-to-DONE latency 2 cycles.
- Next START accepted in cycle after DONE (IDLE); DONE and START in the same cycle: START dropped.
- `rst` mid-transaction: `mem_req`, BUSY deassert at the next edge; no DONE issued; late ack ignored.
- Timeout counter is `addr_width`-independent, width ceil(log2(timeout_cycles+1)); counts REQ cycles; abort when count == `timeout_cycles` without ack; ack on that same cycle wins (DONE, no ERR).

## Configuration
- `MOBO_BUS_TIMEOUT_EN` defined: timeout counter and ERR state present as above.
- Undefined: REQ waits indefinitely for ack; ERR state and counter absent; stat bit2 tied 0; `timeout_cycles` unused.

## Structure
- Shared constants file (included by CPU FSMs and this block): `mobo_ctrl` bit indices (START, WE), `mobo_stat` bit indices (BUSY, DONE, ERR), FSM state encodings.
- One sub-module: `mobo_timeout_cnt` (clear, enable, expire output), instantiated only under `MOBO_BUS_TIMEOUT_EN`.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, no `mem_req`.
- Read 0x0040, ack 3 cycles after req with rdata 0xDEADBEEF -> `mem_req` 3 cycles, DONE pulse once, `mobo_rdata`=0xDEADBEEF, BUSY low on DONE.
- Write 0x1234 data 0xA5A5A5A5, ack same cycle as first req -> `mem_we`=1, `mem_addr`=0x1234, DONE at START+2, `mobo_rdata` unchanged.
- START pulsed during REQ and during DONE -> ignored; only original transaction runs.
- Timeout build, `timeout_cycles`=4, no ack -> `mem_req` 4 cycles then DONE+ERR; next START clears ERR; ack on 4th cycle instead -> DONE, ERR=0.
- `rst` asserted mid-REQ, ack arrives after -> `mem_req` drops next edge, no DONE, state IDLE.
